load_align_unit: RTL

Parametrised load unit that replaces the old combinational load decoder in the RV32IM/RV64IM datapath, sitting between the execute stage and the data-memory port. It accepts one load request at a time, issues aligned word reads over a valid/ready memory handshake, and extracts, shifts and sign- or zero-extends the addressed bytes. Misaligned loads that cross a word boundary are split into two bus reads when the split feature is compiled in; otherwise they raise a fault. Illegal encodings also raise a fault.

---
 rtl/load_pkg.sv | 44 ++++
 rtl/load_align_unit_if.sv | 41 ++++
 rtl/load_extract.sv | 36 +++
 rtl/load_align_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_pkg: shared funct3 encodings, FSM state type and load helpers.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // Low two funct3 bits encode log2 of the access size.
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] f3, input int xlen);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      F3_LD, F3_LWU:                      return (xlen == 64);
      default:                            return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_align_unit_if: request, memory-read and response signal bundle.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface load_align_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();
  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_addr;
  logic [2:0]       req_funct3;
  logic [TAG_W-1:0] req_tag;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [XLEN-1:0]  mem_addr;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_fault;

  // master: the surrounding datapath and memory; slave: the load unit.
  modport master (
    output req_valid, req_addr, req_funct3, req_tag,
    output mem_req_ready, mem_rvalid, mem_rdata, rsp_ready,
    input  req_ready, mem_req_valid, mem_addr,
    input  rsp_valid, rsp_data, rsp_tag, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, req_funct3, req_tag,
    input  mem_req_ready, mem_rvalid, mem_rdata, rsp_ready,
    output req_ready, mem_req_valid, mem_addr,
    output rsp_valid, rsp_data, rsp_tag, rsp_fault
  );
endinterface
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_extract: shift {hi,lo} by the byte offset, truncate to the access   |
// | size and sign/zero-extend to XLEN bits. Revision: 1.0                    |
// +--------------------------------------------------------------------------+
module load_extract
  import load_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]           data_i,
  input  logic [$clog2(XLEN/8)-1:0]   offset_i,
  input  logic [2:0]                  funct3_i,
  output logic [XLEN-1:0]             data_o
);
  localparam int IW = $clog2(2 * XLEN);

  logic [2*XLEN-1:0] shifted_w;
  logic [IW-1:0]     sbit_w;
  logic              fill_w;
  int                nbits_w;

  always_comb begin
    shifted_w = data_i >> {offset_i, 3'b000};
    nbits_w   = 8 * int'(size_bytes(funct3_i));
    sbit_w    = IW'(nbits_w - 1);
    // funct3[2] set selects the unsigned variants.
    fill_w    = !funct3_i[2] && shifted_w[sbit_w];
    data_o    = '0;
    for (int i = 0; i < XLEN; i++) begin
      data_o[i] = (i < nbits_w) ? shifted_w[i] : fill_w;
    end
  end

endmodule
`default_nettype wire

// File: rtl/load_align_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_align_unit: one-at-a-time load unit issuing aligned word reads and  |
// | returning extended results. Define LOAD_ALIGN_SPLIT_EN to split          |
// | word-crossing loads into two reads instead of faulting. Revision: 1.0    |
// +--------------------------------------------------------------------------+
module load_align_unit
  import load_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  load_align_unit_if.slave lsu_if
);
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
`ifdef LOAD_ALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q;
  logic [2:0]        funct3_q;
  logic [TAG_W-1:0]  tag_q;
  logic              fault_q;
  logic [XLEN-1:0]   lo_q;
  logic [XLEN-1:0]   hi_w;
  logic [XLEN-1:0]   aligned_w;
  logic [XLEN-1:0]   ext_w;
  logic              accept_w;
  logic              req_fault_w;
  logic              misal_w;

  function automatic logic crosses(input logic [OFFW-1:0] off, input logic [2:0] f3);
    return (int'(off) + int'(size_bytes(f3))) > BYTES;
  endfunction

  assign accept_w    = (state_q == ST_IDLE) && lsu_if.req_valid;
  assign req_fault_w = !is_legal(lsu_if.req_funct3, XLEN)
                     || (!SPLIT_EN && crosses(lsu_if.req_addr[OFFW-1:0], lsu_if.req_funct3));
  assign misal_w     = crosses(addr_q[OFFW-1:0], funct3_q);
  assign aligned_w   = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      tag_q    <= '0;
      fault_q  <= 1'b0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept_w) begin
        addr_q   <= lsu_if.req_addr;
        funct3_q <= lsu_if.req_funct3;
        tag_q    <= lsu_if.req_tag;
        fault_q  <= req_fault_w;
      end
      if (state_q == ST_WAIT0 && lsu_if.mem_rvalid) lo_q <= lsu_if.mem_rdata;
    end
  end

`ifdef LOAD_ALIGN_SPLIT_EN
  logic [XLEN-1:0] hi_q;
  always_ff @(posedge clk) begin
    if (rst) hi_q <= '0;
    else if (state_q == ST_WAIT1 && lsu_if.mem_rvalid) hi_q <= lsu_if.mem_rdata;
  end
  assign hi_w = hi_q;
`else
  assign hi_w = '0;
`endif

  always_comb begin
    state_d              = state_q;
    lsu_if.req_ready     = 1'b0;
    lsu_if.mem_req_valid = 1'b0;
    lsu_if.mem_addr      = '0;
    lsu_if.rsp_valid     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lsu_if.req_ready = 1'b1;
        if (lsu_if.req_valid) state_d = req_fault_w ? ST_RESP : ST_REQ0;
      end
      ST_REQ0: begin
        lsu_if.mem_req_valid = 1'b1;
        lsu_if.mem_addr      = aligned_w;
        if (lsu_if.mem_req_ready) state_d = ST_WAIT0;
      end
      ST_WAIT0: begin
        if (lsu_if.mem_rvalid) state_d = (SPLIT_EN && misal_w) ? ST_REQ1 : ST_RESP;
      end
`ifdef LOAD_ALIGN_SPLIT_EN
      ST_REQ1: begin
        lsu_if.mem_req_valid = 1'b1;
        lsu_if.mem_addr      = aligned_w + XLEN'(BYTES);
        if (lsu_if.mem_req_ready) state_d = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (lsu_if.mem_rvalid) state_d = ST_RESP;
      end
`endif
      ST_RESP: begin
        lsu_if.rsp_valid = 1'b1;
        if (lsu_if.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  load_extract #(.XLEN(XLEN)) u_extract (
    .data_i   ({hi_w, lo_q}),
    .offset_i (addr_q[OFFW-1:0]),
    .funct3_i (funct3_q),
    .data_o   (ext_w)
  );

  assign lsu_if.rsp_data  = (state_q == ST_RESP && !fault_q) ? ext_w : '0;
  assign lsu_if.rsp_tag   = tag_q;
  assign lsu_if.rsp_fault = (state_q == ST_RESP) && fault_q;

endmodule
`default_nettype wire
